jt1943_rom_arbiter: RTL and testbench
=====================================

# jt1943_rom_arbiter

Shares the single read port of the `jtgng_sdram` controller among up to `SLOTS` ROM requesters (main CPU, sound CPU, char, scroll, object fetchers) in the 1943 game core. Each requester presents an address and chip-select. The arbiter serialises requests into `sdram_req`/`sdram_addr`, then routes the 32-bit `data_read` word back into a per-slot data register. A watchdog recovers from lost `data_rdy` pulses, and all activity is suspended during ROM download.

## Interface
- `SLOTS`, 4: number of requesters, 2..8
- `AW`, 22: SDRAM word address width
- `TIMEOUT`, 255: maximum cycles in WAIT_DATA before abort, 1..255
- `clk`  in  1  system clock (SDRAM clock domain)
- `rst_n`  in  1  asynchronous reset, active low
- `downloading`  in  1  ROM download in progress; blocks and flushes the arbiter
- `slot_cs`  in  SLOTS  per-slot request, level-sensitive
- `slot_addr`  in  SLOTS*AW  per-slot word address; slot i occupies bits [i*AW +: AW]
- `slot_ok`  out  SLOTS  slot data valid for its current address
- `slot_dout`  out  SLOTS*32  per-slot data; slot i occupies bits [i*32 +: 32]
- `sdram_req`  out  1  read request to the SDRAM controller
- `sdram_addr`  out  AW  read address
- `sdram_ack`  in  1  request accepted; single-cycle pulse
- `data_rdy`  in  1  `data_read` valid; single-cycle pulse
- `data_read`  in  32  SDRAM read word
- `busy`  out  1  state is not IDLE
- `timeout_cnt`  out  8  saturating count of watchdog aborts

## Operation
- Per-slot registers:
  - `valid[i]`
  - `tag[i]` (AW bits)
  - `dout[i]` (32 bits)
- `slot_ok[i] = slot_cs[i] & valid[i] & (slot_addr[i] == tag[i])`. This is combinational from those registers and the live inputs.
- `pending[i] = slot_cs[i] & ~slot_ok[i]`.
- FSM has three states:
  - IDLE:
    - Waits while `downloading` is high or no slot is pending.
    - Otherwise selects grant `g` per the arbitration policy (see Configuration).
    - Latches `sdram_addr <= slot_addr[g]`, sets `sdram_req <= 1` and moves to WAIT_ACK.
  - WAIT_ACK:
    - `sdram_req` holds high and `sdram_addr` stays stable.
    - On `sdram_ack`: `sdram_req <= 0`, `timer <= 0`, move to WAIT_DATA.
  - WAIT_DATA:
    - `timer` increments every cycle.
    - On `data_rdy`: `dout[g] <= data_read`, `tag[g] <= sdram_addr`, `valid[g] <= 1`, move to IDLE.
    - If `timer == TIMEOUT` and `data_rdy` is low: move to IDLE without writing, and `timeout_cnt` increments, saturating at 255.
    - `data_rdy` takes precedence over timeout on the same cycle.
- `slot_dout[i]` always drives `dout[i]`, whether `slot_ok` is high or low.
- `downloading` high in any state, highest priority:
  - move to IDLE next cycle;
  - `sdram_req <= 0`;
  - all `valid` cleared;
  - `timer` cleared;
  - `timeout_cnt` retained.
- Address change mid-fetch:
  - The fetch completes with the latched address and the tag is written.
  - `slot_ok` stays low because of the mismatch.
  - The slot becomes pending again and is re-fetched.
- A `slot_cs` drop mid-fetch does not abort the fetch.
- A `sdram_ack` or `data_rdy` arriving in an unexpected state is ignored.

## Timing
- Reset values:
  - `sdram_req` = 0
  - `sdram_addr` = 0
  - `slot_dout` = 0
  - `valid` = 0
  - `tag` = 0
  - state IDLE
  - `busy` = 0
  - `timeout_cnt` = 0
  - RR pointer = SLOTS-1
- Uncontended latency:
  - `slot_cs` seen high in IDLE at cycle 0 → `sdram_req` high at cycle 1.
  - `data_rdy` at cycle n → `slot_ok` high at cycle n+1.
- There is one IDLE cycle between consecutive grants, so the minimum cycle from grant to grant is 3 + SDRAM latency.
- `busy` is registered and is high exactly while the state is not IDLE.
- The watchdog abort lands in IDLE on cycle TIMEOUT+1 after `sdram_ack`.

## Configuration
- `JT1943_ARB_RR_EN` defined:
  - Round-robin policy.
  - The search starts at `last_grant+1` and wraps modulo SLOTS.
  - `last_grant <= g` on each grant.
- Not defined:
  - Fixed priority; the lowest pending index wins. Slot 0 is the main CPU.
  - The `last_grant` register is not present.

## Test plan
- Slot 1 requests 0x01234 alone. The SDRAM model gives ack at +2 and rdy at +5 with 0xDEADBEEF. Required: `sdram_addr` = 0x01234, `slot_dout[1]` = 0xDEADBEEF, `slot_ok[1]` high 1 cycle after rdy, other `slot_ok` low.
- Slots 0, 2 and 3 request simultaneously and hold:
  - RR order is 0, 2, 3 from reset.
  - Fixed-priority order is also 0, 2, 3.
  - Re-requesting slot 0 with a new address before slot 3 is served: RR serves 3 first, fixed priority serves 0 first.
- Slot 2 address changes from 0x00100 to 0x00200 while in WAIT_DATA. Required: `tag[2]` = 0x00100, `slot_ok[2]` stays low, a second fetch of 0x00200 is issued, then `slot_ok[2]` goes high.
- `TIMEOUT` = 10 and the model withholds `data_rdy`. Required: abort 11 cycles after ack, `timeout_cnt` = 1, slot re-fetched and served; with 300 aborts `timeout_cnt` saturates at 255.
- `downloading` asserted in WAIT_ACK with `slot_ok[0]` high. Required: `sdram_req` low and `slot_ok[0]` low next cycle, no request while `downloading` is high, refetch after it falls.
- Assert `rst_n` low mid-WAIT_DATA. Required: all outputs return to their reset values immediately; a later `data_rdy` has no effect.

Source files
------------

// File: rtl/jt1943_rom_arbiter.sv
// Serialises up to SLOTS ROM requesters onto the single jtgng_sdram read port and caches one word per slot.
// Define JT1943_ARB_RR_EN for round-robin arbitration; the default build uses fixed priority (slot 0 highest).
module jt1943_rom_arbiter #(
    parameter int SLOTS   = 4,
    parameter int AW      = 22,
    parameter int TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                downloading,
    input  logic [SLOTS-1:0]    slot_cs,
    input  logic [SLOTS*AW-1:0] slot_addr,
    output logic [SLOTS-1:0]    slot_ok,
    output logic [SLOTS*32-1:0] slot_dout,
    output logic                sdram_req,
    output logic [AW-1:0]       sdram_addr,
    input  logic                sdram_ack,
    input  logic                data_rdy,
    input  logic [31:0]         data_read,
    output logic                busy,
    output logic [7:0]          timeout_cnt
);
    localparam int GW = $clog2(SLOTS);

    typedef enum logic [1:0] {IDLE, WAIT_ACK, WAIT_DATA} state_t;
    state_t state, state_nx;

    logic [SLOTS-1:0] valid;
    logic [AW-1:0]    tag  [SLOTS];
    logic [31:0]      dout [SLOTS];
    logic [SLOTS-1:0] pending;
    logic [GW-1:0]    grant;
    logic [GW-1:0]    pick;
    logic [7:0]       timer;
    logic             any_pending;
    logic             timed_out;

    genvar i;
    generate
        for (i = 0; i < SLOTS; i++) begin : g_slot
            assign slot_ok[i]            = slot_cs[i] & valid[i] & (slot_addr[i*AW +: AW] == tag[i]);
            assign slot_dout[i*32 +: 32] = dout[i];
        end
    endgenerate

    assign pending     = slot_cs & ~slot_ok;
    assign any_pending = |pending;
    assign timed_out   = (timer == 8'(TIMEOUT));

`ifdef JT1943_ARB_RR_EN
    logic [GW-1:0] last_grant;

    // Walk downwards so the slot nearest last_grant+1 is written last and wins.
    always_comb begin
        logic [GW-1:0] idx;
        pick = '0;
        idx  = '0;
        for (int k = SLOTS; k >= 1; k--) begin
            idx = GW'((int'(last_grant) + k) % SLOTS);
            if (pending[idx]) pick = idx;
        end
    end
`else
    always_comb begin
        pick = '0;
        for (int k = SLOTS-1; k >= 0; k--) begin
            if (pending[k]) pick = GW'(k);
        end
    end
`endif

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:      if (any_pending) state_nx = WAIT_ACK;
            WAIT_ACK:  if (sdram_ack) state_nx = WAIT_DATA;
            WAIT_DATA: if (data_rdy || timed_out) state_nx = IDLE;
            default:   state_nx = IDLE;
        endcase
        if (downloading) state_nx = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            busy  <= 1'b0;
        end else begin
            state <= state_nx;
            busy  <= (state_nx != IDLE);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sdram_req   <= 1'b0;
            sdram_addr  <= '0;
            grant       <= '0;
            timer       <= '0;
            valid       <= '0;
            timeout_cnt <= '0;
            for (int k = 0; k < SLOTS; k++) begin
                tag[k]  <= '0;
                dout[k] <= '0;
            end
`ifdef JT1943_ARB_RR_EN
            last_grant  <= GW'(SLOTS-1);
`endif
        end else if (downloading) begin
            // ROM contents are being rewritten: every cached word is stale.
            sdram_req <= 1'b0;
            valid     <= '0;
            timer     <= '0;
        end else begin
            case (state)
                IDLE: if (any_pending) begin
                    grant      <= pick;
                    sdram_addr <= slot_addr[int'(pick)*AW +: AW];
                    sdram_req  <= 1'b1;
`ifdef JT1943_ARB_RR_EN
                    last_grant <= pick;
`endif
                end
                WAIT_ACK: if (sdram_ack) begin
                    sdram_req <= 1'b0;
                    timer     <= '0;
                end
                WAIT_DATA: begin
                    timer <= timer + 8'd1;
                    if (data_rdy) begin
                        dout[grant]  <= data_read;
                        tag[grant]   <= sdram_addr;
                        valid[grant] <= 1'b1;
                    end else if (timed_out && timeout_cnt != 8'hFF) begin
                        timeout_cnt <= timeout_cnt + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_jt1943_rom_arbiter.sv
// Directed bench for jt1943_rom_arbiter: vector table of single fetches plus hand-written multi-cycle sequences.
module tb_jt1943_rom_arbiter;
    localparam int SLOTS = 4;
    localparam int AW    = 22;

    logic                clk = 1'b0;
    logic                rst_n = 1'b1;
    logic                downloading = 1'b0;
    logic [SLOTS-1:0]    slot_cs = '0;
    logic [SLOTS*AW-1:0] slot_addr = '0;
    logic [SLOTS-1:0]    slot_ok;
    logic [SLOTS*32-1:0] slot_dout;
    logic                sdram_req;
    logic [AW-1:0]       sdram_addr;
    logic                sdram_ack = 1'b0;
    logic                data_rdy = 1'b0;
    logic [31:0]         data_read = '0;
    logic                busy;
    logic [7:0]          timeout_cnt;

    int checks = 0;
    int errors = 0;

    jt1943_rom_arbiter #(.SLOTS(SLOTS), .AW(AW), .TIMEOUT(10)) dut (
        .clk(clk), .rst_n(rst_n), .downloading(downloading),
        .slot_cs(slot_cs), .slot_addr(slot_addr), .slot_ok(slot_ok), .slot_dout(slot_dout),
        .sdram_req(sdram_req), .sdram_addr(sdram_addr), .sdram_ack(sdram_ack),
        .data_rdy(data_rdy), .data_read(data_read), .busy(busy), .timeout_cnt(timeout_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          slot;
        logic [21:0] addr;
        logic [31:0] data;
        int          ack_dly;
        int          rdy_dly;
        logic [3:0]  exp_ok;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // SDRAM model: ack ack_dly cycles after req is seen, data_rdy rdy_dly cycles after req is seen.
    task automatic fetch(input int ack_dly, input int rdy_dly, input logic [31:0] d,
                         output logic [21:0] a_seen);
        int w = 0;
        while (!sdram_req && w < 50) begin
            tick();
            w++;
        end
        chk("req_seen", sdram_req, 1);
        a_seen = sdram_addr;
        if (!sdram_req) return;
        repeat (ack_dly) tick();
        chk("req_held", sdram_req, 1);
        sdram_ack = 1'b1;
        tick();
        sdram_ack = 1'b0;
        chk("req_drop", sdram_req, 0);
        chk("busy_wait_data", busy, 1);
        repeat (rdy_dly - ack_dly - 1) tick();
        data_read = d;
        data_rdy  = 1'b1;
        tick();
        data_rdy  = 1'b0;
    endtask

    // Acks a request but never returns data; n = cycles from the ack edge until back in IDLE.
    task automatic abort_one(output int n);
        int w = 0;
        n = 0;
        while (!sdram_req && w < 50) begin
            tick();
            w++;
        end
        if (!sdram_req) begin
            chk("abort_req_seen", sdram_req, 1);
            return;
        end
        sdram_ack = 1'b1;
        tick();
        sdram_ack = 1'b0;
        while (busy && n < 40) begin
            tick();
            n++;
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        vec_t        vecs [4];
        logic [21:0] a;
        logic [21:0] exp_order [4];
        int          n;
        int          bad;

        vecs[0] = '{1, 22'h01234,  32'hDEADBEEF, 2, 5, 4'b0010};
        vecs[1] = '{0, 22'h3FFFFF, 32'h12345678, 1, 2, 4'b0001};
        vecs[2] = '{3, 22'h00000,  32'hA5A5A5A5, 3, 9, 4'b1000};
        vecs[3] = '{2, 22'h2AAAAA, 32'hFFFFFFFF, 1, 3, 4'b0100};
`ifdef JT1943_ARB_RR_EN
        exp_order = '{22'h00A00, 22'h00C00, 22'h00D00, 22'h00A44};
`else
        exp_order = '{22'h00A00, 22'h00C00, 22'h00A44, 22'h00D00};
`endif

        // Reset values, with all chip-selects high so valid gating is exercised.
        #1 rst_n = 1'b0;
        slot_cs = 4'hF;
        repeat (3) tick();
        chk("rst_req", sdram_req, 0);
        chk("rst_addr", sdram_addr, 0);
        chk("rst_busy", busy, 0);
        chk("rst_tocnt", timeout_cnt, 0);
        chk("rst_dout_zero", |slot_dout, 0);
        chk("rst_ok", slot_ok, 0);
        slot_cs = '0;
        rst_n = 1'b1;
        tick();

        // Single uncontended fetches.
        for (int v = 0; v < 4; v++) begin
            slot_cs = '0;
            slot_cs[vecs[v].slot] = 1'b1;
            slot_addr[vecs[v].slot*AW +: AW] = vecs[v].addr;
            tick();
            chk("req_latency", sdram_req, 1);
            fetch(vecs[v].ack_dly, vecs[v].rdy_dly, vecs[v].data, a);
            chk("vec_addr", a, vecs[v].addr);
            chk("vec_ok", slot_ok, vecs[v].exp_ok);
            chk("vec_dout", slot_dout[vecs[v].slot*32 +: 32], vecs[v].data);
            chk("vec_idle", busy, 0);
        end

        // Arbitration order from reset, with slot 0 re-requesting before slot 3 is served.
        slot_cs = '0;
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        slot_addr[0*AW +: AW] = 22'h00A00;
        slot_addr[2*AW +: AW] = 22'h00C00;
        slot_addr[3*AW +: AW] = 22'h00D00;
        slot_cs = 4'b1101;
        for (int k = 0; k < 4; k++) begin
            fetch(1, 3, 32'h0000_1000 + k, a);
            chk("arb_order", a, exp_order[k]);
            if (k == 1) slot_addr[0*AW +: AW] = 22'h00A44;
        end
        chk("arb_all_ok", slot_ok, 4'b1101);

        // Address change while the fetch is in flight.
        slot_cs = 4'b0100;
        slot_addr[2*AW +: AW] = 22'h00100;
        tick();
        chk("chg_req", sdram_req, 1);
        chk("chg_addr1", sdram_addr, 22'h00100);
        sdram_ack = 1'b1;
        tick();
        sdram_ack = 1'b0;
        slot_addr[2*AW +: AW] = 22'h00200;
        repeat (2) tick();
        data_read = 32'h11111111;
        data_rdy  = 1'b1;
        tick();
        data_rdy  = 1'b0;
        chk("chg_tag", dut.tag[2], 22'h00100);
        chk("chg_ok_low", slot_ok[2], 0);
        fetch(1, 2, 32'h22222222, a);
        chk("chg_addr2", a, 22'h00200);
        chk("chg_ok_high", slot_ok[2], 1);
        chk("chg_dout", slot_dout[2*32 +: 32], 32'h22222222);

        // Watchdog abort, refetch, then saturation.
        slot_cs = 4'b0010;
        slot_addr[1*AW +: AW] = 22'h05555;
        abort_one(n);
        chk("abort_cycles", n, 11);
        chk("abort_tocnt", timeout_cnt, 1);
        chk("abort_ok_low", slot_ok[1], 0);
        fetch(2, 4, 32'h33333333, a);
        chk("abort_refetch_addr", a, 22'h05555);
        chk("abort_refetch_ok", slot_ok[1], 1);
        chk("abort_refetch_dout", slot_dout[1*32 +: 32], 32'h33333333);
        slot_addr[1*AW +: AW] = 22'h06666;
        bad = 0;
        for (int k = 0; k < 300; k++) begin
            abort_one(n);
            if (n != 11) bad++;
        end
        chk("abort_loop_cycles", bad, 0);
        chk("tocnt_saturate", timeout_cnt, 8'hFF);

        // Download in WAIT_ACK while slot 0 holds valid data.
        slot_cs = 4'b0001;
        slot_addr[0*AW +: AW] = 22'h00777;
        fetch(1, 2, 32'h44444444, a);
        slot_addr[3*AW +: AW] = 22'h00888;
        slot_cs = 4'b1001;
        tick();
        chk("dl_req_before", sdram_req, 1);
        chk("dl_addr_before", sdram_addr, 22'h00888);
        chk("dl_ok0_before", slot_ok[0], 1);
        downloading = 1'b1;
        tick();
        chk("dl_req_low", sdram_req, 0);
        chk("dl_ok0_low", slot_ok[0], 0);
        chk("dl_busy_low", busy, 0);
        bad = 0;
        for (int k = 0; k < 5; k++) begin
            sdram_ack = (k == 2);
            tick();
            if (sdram_req || busy) bad++;
        end
        sdram_ack = 1'b0;
        chk("dl_no_request", bad, 0);
        chk("dl_tocnt_kept", timeout_cnt, 8'hFF);
        downloading = 1'b0;
        tick();
        chk("dl_refetch_req", sdram_req, 1);
        fetch(1, 2, 32'h55555555, a);
        chk("dl_refetch0", a, 22'h00777);
        fetch(1, 2, 32'h66666666, a);
        chk("dl_refetch3", a, 22'h00888);
        chk("dl_ok_final", slot_ok, 4'b1001);

        // Asynchronous reset in WAIT_DATA, then a stray data_rdy.
        slot_cs = 4'b0010;
        slot_addr[1*AW +: AW] = 22'h07777;
        tick();
        chk("rst2_req", sdram_req, 1);
        sdram_ack = 1'b1;
        tick();
        sdram_ack = 1'b0;
        tick();
        #1 rst_n = 1'b0;
        #1;
        chk("rst2_req_low", sdram_req, 0);
        chk("rst2_addr", sdram_addr, 0);
        chk("rst2_busy", busy, 0);
        chk("rst2_tocnt", timeout_cnt, 0);
        chk("rst2_dout_zero", |slot_dout, 0);
        chk("rst2_ok", slot_ok, 0);
        slot_cs = '0;
        tick();
        rst_n = 1'b1;
        tick();
        data_read = 32'h77777777;
        data_rdy  = 1'b1;
        tick();
        data_rdy  = 1'b0;
        chk("rst2_stray_dout", |slot_dout, 0);
        chk("rst2_stray_busy", busy, 0);
        slot_cs = 4'b0010;
        #1;
        chk("rst2_ok_after", slot_ok, 0);
        tick();
        chk("rst2_new_req", sdram_req, 1);
        chk("rst2_new_addr", sdram_addr, 22'h07777);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
